// File: rtl/dffram_host_bridge.sv
// dffram_host_bridge
//
// Host-side initiator for the byte-serial DFFRAM pin interface. It accepts one
// 32-bit word request at a time and turns it into byte-wide pin cycles. Read
// bytes are put back together into a 32-bit response.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready is combinational)
//   req_write             1 = write, 0 = read
//   req_addr[4:0]         word address
//   req_wdata[31:0]       write data, byte k = bits [8k+7:8k]
//   req_wstrb[3:0]        byte write enables
//   rsp_valid/rsp_ready   response handshake (rsp_* registered)
//   rsp_write             response is a write ack
//   rsp_rdata[31:0]       read data, 0 for write acks
//   mem_ui[7:0]           to RAM ui_in: {WE, addr[4:0], byte[1:0]}
//   mem_uio[7:0]          to RAM uio_in: write byte
//   mem_uo[7:0]           from RAM uo_out: read byte
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | req_ready high, waiting for a request
// S_WRITE | one WE pin cycle per enabled byte, ascending byte order
// S_READ  | byte addresses 0..3 on mem_ui, WE low
// S_DRAIN | mem_ui idle, waiting for the byte 3 capture
// S_RESP  | response held stable until rsp_ready

module dffram_host_bridge #(
    parameter int READ_LATENCY = 1   // legal range 1..3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  mem_ui,
    output logic [7:0]  mem_uio,
    input  logic [7:0]  mem_uo
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      state;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;      // enabled bytes not yet written
    logic [31:0] rdata_q;
    logic [31:0] rdata_nxt;

    // Tag pipeline: stage 0 holds the byte index driven in the previous cycle,
    // so the last stage lines up with the RAM's read latency.
    logic [READ_LATENCY-1:0] tag_vld;
    logic [1:0]              tag_k [READ_LATENCY];
    logic                    cap_fire;
    logic [1:0]              cap_k;

    logic       accept;
    logic [1:0] first_k;
    logic [1:0] next_k;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] k;
        k = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) k = 2'(i);
        end
        return k;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    assign req_ready = rst_n && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign first_k   = lowest_set(req_wstrb);
    assign next_k    = lowest_set(wmask_q);
    assign cap_fire  = tag_vld[READ_LATENCY-1];
    assign cap_k     = tag_k[READ_LATENCY-1];

    always_comb begin
        rdata_nxt = rdata_q;
        if (cap_fire) rdata_nxt[{cap_k, 3'b000} +: 8] = mem_uo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            mem_ui    <= '0;
            mem_uio   <= '0;
            tag_vld   <= '0;
            for (int j = 0; j < READ_LATENCY; j++) tag_k[j] <= '0;
        end else begin
            tag_vld[0] <= (state == S_READ);
            tag_k[0]   <= mem_ui[1:0];
            for (int j = 1; j < READ_LATENCY; j++) begin
                tag_vld[j] <= tag_vld[j-1];
                tag_k[j]   <= tag_k[j-1];
            end
            rdata_q <= rdata_nxt;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_write) begin
                            if (req_wstrb == 4'b0000) begin
                                rsp_valid <= 1'b1;
                                rsp_write <= 1'b1;
                                rsp_rdata <= '0;
                                state     <= S_RESP;
                            end else begin
                                // First enabled byte goes out on the accept edge.
                                mem_ui  <= {1'b1, req_addr, first_k};
                                mem_uio <= byte_of(req_wdata, first_k);
                                wmask_q <= req_wstrb & ~(4'b0001 << first_k);
                                state   <= S_WRITE;
                            end
                        end else begin
                            mem_ui  <= {1'b0, req_addr, 2'd0};
                            mem_uio <= '0;
                            rdata_q <= '0;
                            state   <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (wmask_q != 4'b0000) begin
                        mem_ui  <= {1'b1, addr_q, next_k};
                        mem_uio <= byte_of(wdata_q, next_k);
                        wmask_q <= wmask_q & ~(4'b0001 << next_k);
                    end else begin
                        mem_ui    <= '0;
                        mem_uio   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= S_RESP;
                    end
                end
                S_READ: begin
                    if (mem_ui[1:0] == 2'd3) begin
                        mem_ui <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        mem_ui[1:0] <= mem_ui[1:0] + 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (cap_fire && (cap_k == 2'd3)) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= rdata_nxt;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_host_bridge.sv
// tb_dffram_host_bridge
//
// Drives two bridges (READ_LATENCY 1 and 3), each attached to a byte-wide RAM
// model with matching read latency. Expected responses come from a word-level
// shadow memory and are queued when a request is issued, then popped when the
// bridge raises rsp_valid.

module tb_dffram_host_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [4:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_write [2];
    logic [31:0] rsp_rdata [2];
    logic [7:0]  mem_ui    [2];
    logic [7:0]  mem_uio   [2];
    logic [7:0]  mem_uo    [2];

    dffram_host_bridge #(.READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
        .rsp_rdata(rsp_rdata[0]),
        .mem_ui(mem_ui[0]), .mem_uio(mem_uio[0]), .mem_uo(mem_uo[0])
    );

    dffram_host_bridge #(.READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
        .rsp_rdata(rsp_rdata[1]),
        .mem_ui(mem_ui[1]), .mem_uio(mem_uio[1]), .mem_uo(mem_uo[1])
    );

    // Pin-level RAM models: index {addr, byte}; read data appears 1 or 3 cycles
    // after the address cycle.
    logic [7:0] ram [2][128];
    logic [7:0] rd0 [2];
    logic [7:0] rd1 [2];
    logic [7:0] rd2 [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ui[d][7]) ram[d][mem_ui[d][6:0]] <= mem_uio[d];
            rd0[d] <= ram[d][mem_ui[d][6:0]];
            rd1[d] <= rd0[d];
            rd2[d] <= rd1[d];
        end
    end
    assign mem_uo[0] = rd0[0];
    assign mem_uo[1] = rd2[1];

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] shadow [2][32];
    logic [7:0]  we_ui  [$];
    logic [7:0]  we_uio [$];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request/response transaction. exp_cyc counts cycles after the accept
    // edge (cycle 1 = first cycle after it) until rsp_valid is seen.
    task automatic xact(input int d, input logic wr, input logic [4:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int exp_cyc, input int exp_we, input logic stall,
                        input string tag);
        exp_t e;
        int   cyc;
        e.wr  = wr;
        e.cyc = exp_cyc;
        if (wr) begin
            e.rdata = 32'h0;
            for (int k = 0; k < 4; k++)
                if (ws[k]) shadow[d][a][8*k +: 8] = wd[8*k +: 8];
        end else begin
            e.rdata = shadow[d][a];
        end
        sb.push_back(e);
        we_ui.delete();
        we_uio.delete();

        rsp_ready[d] = !stall;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_wstrb[d] = ws;
        chk({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        cyc = 1;
        while (!rsp_valid[d] && cyc < 40) begin
            if (mem_ui[d][7]) begin
                we_ui.push_back(mem_ui[d]);
                we_uio.push_back(mem_uio[d]);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (mem_ui[d][7]) begin
            we_ui.push_back(mem_ui[d]);
            we_uio.push_back(mem_uio[d]);
        end

        e = sb.pop_front();
        chk({tag, " rsp cycle"}, 32'(cyc), 32'(e.cyc));
        chk({tag, " rsp_write"}, 32'(rsp_write[d]), 32'(e.wr));
        chk({tag, " rsp_rdata"}, rsp_rdata[d], e.rdata);
        chk({tag, " we cycles"}, 32'(we_ui.size()), 32'(exp_we));

        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk($sformatf("%s hold%0d rsp_valid", tag, i), 32'(rsp_valid[d]), 32'd1);
                chk($sformatf("%s hold%0d rsp_rdata", tag, i), rsp_rdata[d], e.rdata);
                chk($sformatf("%s hold%0d req_ready", tag, i), 32'(req_ready[d]), 32'd0);
            end
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, " post rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, " post req_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eu   [4];
        logic [7:0] euio [4];
        int         bad;

        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_wstrb[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d req_ready", d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("rst%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("rst%0d rsp_write", d), 32'(rsp_write[d]), 32'd0);
            chk($sformatf("rst%0d rsp_rdata", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst%0d mem_ui", d), 32'(mem_ui[d]), 32'd0);
            chk($sformatf("rst%0d mem_uio", d), 32'(mem_uio[d]), 32'd0);
            rst_n[d] = 1'b1;
        end
        #1;

        // Full write then read-back of addr 5
        xact(0, 1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 5, 4, 1'b0, "w5");
        eu   = '{8'h94, 8'h95, 8'h96, 8'h97};
        euio = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w5 ui%0d", i), 32'(we_ui[i]), 32'(eu[i]));
            chk($sformatf("w5 uio%0d", i), 32'(we_uio[i]), 32'(euio[i]));
        end
        xact(0, 1'b0, 5'd5, 32'h0, 4'b0000, 6, 0, 1'b0, "r5");

        // Partial strobe merge at addr 0
        xact(0, 1'b1, 5'd0, 32'h11223344, 4'b1111, 5, 4, 1'b0, "w0a");
        xact(0, 1'b1, 5'd0, 32'hAABBCCDD, 4'b0101, 3, 2, 1'b0, "w0b");
        eu   = '{8'h80, 8'h82, 8'h00, 8'h00};
        euio = '{8'hDD, 8'hBB, 8'h00, 8'h00};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("w0b ui%0d", i), 32'(we_ui[i]), 32'(eu[i]));
            chk($sformatf("w0b uio%0d", i), 32'(we_uio[i]), 32'(euio[i]));
        end
        xact(0, 1'b0, 5'd0, 32'h0, 4'b0000, 6, 0, 1'b0, "r0");

        // Empty strobe: immediate ack, memory untouched
        xact(0, 1'b1, 5'd5, 32'h12345678, 4'b0000, 1, 0, 1'b0, "w5z");
        xact(0, 1'b0, 5'd5, 32'h0, 4'b0000, 6, 0, 1'b0, "r5z");

        // Response back-pressure, then back-to-back read
        xact(0, 1'b0, 5'd0, 32'h0, 4'b0000, 6, 0, 1'b1, "r0stall");
        xact(0, 1'b0, 5'd5, 32'h0, 4'b0000, 6, 0, 1'b0, "r5b2b");

        // Reset during read byte 2 of addr 31
        xact(0, 1'b1, 5'd31, 32'hCAFE0123, 4'b1111, 5, 4, 1'b0, "w31");
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 5'd31;
        req_wstrb[0] = 4'b0000;
        chk("abort req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort byte2 mem_ui", 32'(mem_ui[0]), 32'h7E);
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort mem_ui", 32'(mem_ui[0]), 32'h00);
        chk("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort req_ready in rst", 32'(req_ready[0]), 32'd0);
        rst_n[0] = 1'b1;
        #1;
        chk("abort req_ready after rst", 32'(req_ready[0]), 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[0] || mem_ui[0][7]) bad++;
        end
        chk("abort quiet", 32'(bad), 32'd0);
        xact(0, 1'b0, 5'd31, 32'h0, 4'b0000, 6, 0, 1'b0, "r31");

        // READ_LATENCY = 3 instance
        xact(1, 1'b1, 5'd31, 32'h01020304, 4'b1111, 5, 4, 1'b0, "L3 w31");
        xact(1, 1'b0, 5'd31, 32'h0, 4'b0000, 8, 0, 1'b0, "L3 r31");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dffram_host_bridge.md
Name: dffram_host_bridge

Overview:
- Host-side initiator for the byte-serial DFFRAM pin interface. The RAM macro exposes `ui[7]` = WE, `ui[6:2]` = word address, `ui[1:0]` = byte index, `uio` = write byte, and `uo` = read byte.
- Converts 32-bit word read/write requests on a valid/ready port into sequences of byte-wide pin cycles. Reassembles read bytes into a 32-bit response.
- Used in test harnesses and SoC-side glue that drive the RAM through its 8-bit pins.

Parameters:
- READ_LATENCY, 1, cycles from byte address driven on `mem_ui` to corresponding byte valid on `mem_uo`; legal range 1..3.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- req_valid  input  1  request valid
- req_ready  output  1  bridge can accept request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  5  word address
- req_wdata  input  32  write data; byte k = bits [8k+7:8k]
- req_wstrb  input  4  byte write enables
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed
- rsp_write  output  1  response is write ack
- rsp_rdata  output  32  read data; 0 for write acks
- mem_ui  output  8  to RAM `ui_in`: {WE, addr[4:0], byte[1:0]}
- mem_uio  output  8  to RAM `uio_in`: write byte
- mem_uo  input  8  from RAM `uo_out`: read byte

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. Reset values:
  - state IDLE, req_ready 0 while rst_n low
  - rsp_valid 0, rsp_write 0, rsp_rdata 0
  - mem_ui 8'h00, mem_uio 8'h00
  - capture pipeline cleared
- All mem_* outputs and rsp_* outputs are registered. req_ready is combinational: 1 iff state == IDLE and rst_n high.
- One outstanding transaction. A request is accepted on an edge with req_valid && req_ready; req_addr, req_wdata, req_wstrb and req_write are latched at that edge.
- States: IDLE, WRITE, READ, DRAIN, RESP.
- WRITE:
  - Visits bytes k = 0..3 in ascending order. Bytes with wstrb[k] = 0 are skipped and cost no cycles.
  - For each enabled byte, drives one cycle of mem_ui = {1, addr, k} and mem_uio = wdata byte k.
  - After the last enabled byte: mem_ui/mem_uio return to 0 and the block enters RESP.
  - With wstrb = 1111, accept at edge E0 gives WE cycles 1..4 and rsp_valid high from cycle 5.
  - With wstrb = 0000, no WE cycle occurs and rsp_valid is high in cycle 1.
- READ:
  - Drives mem_ui = {0, addr, k} in cycles 1..4 for k = 0..3; mem_uio = 0.
  - A tag pipeline of depth READ_LATENCY carries k. Byte k is captured from mem_uo at the end of cycle 1+k+READ_LATENCY into rdata[8k+7:8k].
  - DRAIN holds mem_ui = 0 until the byte 3 capture completes, then the block enters RESP.
  - rsp_valid is high from cycle 5+READ_LATENCY (cycle 6 at default).
- RESP:
  - rsp_valid, rsp_write and rsp_rdata stay stable until an edge with rsp_ready high, then the block returns to IDLE.
  - If rsp_ready is already high, rsp_valid lasts exactly one cycle.
  - The next request is accepted no earlier than the edge after the response handshake.
- WE (mem_ui[7]) is never high outside WRITE byte cycles. WE is never high during READ or DRAIN.
- Reset mid-operation aborts the transaction. No response is produced, partially captured rdata is discarded, and mem_ui = 0 from the cycle after the reset edge.
- A bridge reset never causes WE on any cycle.
- Word address wraps naturally within 5 bits. No address arithmetic is performed.

Test Plan:
- Write addr 5, wdata 32'hDEADBEEF, wstrb 1111, then read addr 5 against a RAM model with 1-cycle latency:
  - write shows mem_ui 8'h94, 8'h95, 8'h96, 8'h97 with mem_uio EF, BE, AD, DE
  - rsp_write 1 in cycle 5
  - read returns rsp_rdata 32'hDEADBEEF in cycle 6
- Write addr 0 with 32'h11223344, wstrb 1111, then write addr 0 with 32'hAABBCCDD, wstrb 0101:
  - second write has exactly 2 WE cycles (bytes 0 and 2), ack in cycle 3
  - subsequent read returns 32'h11BB33DD
- Write with wstrb 0000 -> no WE cycle, rsp_valid in cycle 1, RAM contents unchanged.
- Read with rsp_ready held low for 5 cycles:
  - rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout
  - after the rsp_ready pulse, req_ready is 1 the next cycle
  - back-to-back read is accepted
- Reset asserted during read byte 2 -> next cycle mem_ui 8'h00, rsp_valid 0, req_ready 1 after rst_n rises; a following read of addr 31 returns correct data.
- READ_LATENCY = 3 with a 3-cycle RAM model:
  - read addr 31 of 32'h01020304 returns 32'h01020304, rsp_valid in cycle 8
  - mem_ui[7] stays 0 throughout
